body_scan_scheduler: RTL
========================

// Module: body_scan_scheduler
// PURPOSE
//  Owns the snake body segment store and sequences it for the graphic path.
//  Per 8x8 block, on scan_start it walks body_count over segments 0..snake_length-1.
//  It presents snake_body_x/y for each segment and flags whether the queried block holds a body segment.
//  It arbitrates the store between graphic scans (priority) and game-logic moves.
// PARAMETERS
//  SNAKE_LENGTH_BIT  6   width of body_count
//  MAX_SEGMENTS      16  depth of segment store (snake_length 0..15 used)
//  COORD_BIT         7   width of every block coordinate
// PORTS
//  clock_25      in   1   pixel clock, all logic on rising edge
//  reset         in   1   asynchronous, active-low; clears everything
//  scan_start    in   1   1-cycle pulse: start body scan for (x_block,y_block)
//  x_block       in   7   queried block column, latched at scan_start
//  y_block       in   7   queried block row, latched at scan_start
//  snake_length  in   4   number of body segments, latched at scan_start
//  move_req      in   1   level: game logic requests one snake advance
//  head_x        in   7   old head column, pushed into segment 0 on move
//  head_y        in   7   old head row, pushed into segment 0 on move
//  move_ack      out  1   1-cycle pulse: move applied this cycle
//  body_count    out  6   index of segment currently presented
//  snake_body_x  out  7   seg_x[body_count], combinational read
//  snake_body_y  out  7   seg_y[body_count], combinational read
//  scan_busy     out  1   high in SCAN state
//  scan_done     out  1   1-cycle pulse, body_hit valid from this cycle
//  body_hit      out  1   1 if any scanned segment == latched (x_block,y_block)
// BEHAVIOUR
//  Reset: state IDLE; all seg_x/seg_y = 0; body_count = 0.
//  Reset: move_ack, scan_busy, scan_done and body_hit = 0; hit accumulator = 0.
//  Reset mid-scan or mid-move aborts immediately: no scan_done, no move_ack, store cleared.
//  FSM states: IDLE, SCAN, DONE, MOVE.
//  IDLE: if scan_start, go to SCAN, or to DONE if latched length==0.
//    On that entry: latch x/y_block and snake_length; clear body_count and the accumulator.
//    Else if move_req, go to MOVE. scan_start always wins over move_req when both are high.
//  SCAN: compares seg[body_count] to the latch each cycle and ORs the result into the accumulator.
//    If body_count == len-1, go to DONE and set body_hit = acc | current match.
//    Otherwise body_count increments.
//  DONE: scan_done = 1 for one cycle. Next state is MOVE if move_req is high, else IDLE.
//  MOVE: one cycle. Shift seg[i] <= seg[i-1] for i = 15..1, and seg[0] <= (head_x, head_y).
//    Old seg[15] is lost. move_ack = 1 this cycle, then go to IDLE.
//  Move handshake: move_req held until move_ack; requester drops it the cycle after ack.
//    A still-high move_req in IDLE is taken as a further move.
//  Latency: scan_start at edge T -> scan_done high in cycle T+L+1, L = latched length.
//    L = 0 gives T+1 with body_hit = 0.
//  Latency: move_req seen in IDLE -> move_ack next cycle. During a scan, move_ack in the cycle after DONE.
//  scan_start while in SCAN, DONE or MOVE is ignored (not queued).
//  Input changes mid-scan: snake_length, x_block and y_block are not re-sampled; the latched copies are used.
//  body_hit holds its value until the next scan reaches DONE.
//  body_count holds its last value outside SCAN. Its upper bits beyond 4 are always 0.
//  Comparisons are exact 7-bit equality on both coordinates. No wrap arithmetic is performed.
// TESTING
//  1 Reset, then 3 moves with heads (5,5),(6,5),(7,5) -> move_ack 1 cycle after each req;
//    seg0=(7,5), seg1=(6,5), seg2=(5,5).
//  2 len=3, scan_start for (6,5) -> body_count 0,1,2 on 3 cycles, snake_body_x 7,6,5;
//    scan_done at T+4; body_hit=1.
//  3 len=3, query (9,9) -> body_hit=0 at T+4. len=0, query (7,5) -> scan_done at T+1, body_hit=0.
//  4 scan_start and move_req same cycle, len=3 -> scan completes on the pre-move store;
//    move_ack at T+5; seg0 = new head.
//  5 len=3, change snake_length to 10 mid-scan -> still 3 segments, scan_done at T+4.
//  6 reset asserted at cycle 2 of a scan -> all outputs 0 asynchronously, no scan_done, store reads 0.

Source files
------------

// File: rtl/body_scan_scheduler_if.sv
//----------------------------------------------------------------------------
// body_scan_scheduler_if : scan/move handshake bundle for body_scan_scheduler
// Revision 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface body_scan_scheduler_if #(
  parameter int SNAKE_LENGTH_BIT = 6,
  parameter int MAX_SEGMENTS     = 16,
  parameter int COORD_BIT        = 7
);
  localparam int LEN_BIT = $clog2(MAX_SEGMENTS);

  logic                        scan_start;
  logic [COORD_BIT-1:0]        x_block;
  logic [COORD_BIT-1:0]        y_block;
  logic [LEN_BIT-1:0]          snake_length;
  logic                        move_req;
  logic [COORD_BIT-1:0]        head_x;
  logic [COORD_BIT-1:0]        head_y;
  logic                        move_ack;
  logic [SNAKE_LENGTH_BIT-1:0] body_count;
  logic [COORD_BIT-1:0]        snake_body_x;
  logic [COORD_BIT-1:0]        snake_body_y;
  logic                        scan_busy;
  logic                        scan_done;
  logic                        body_hit;

  modport master (
    output scan_start, x_block, y_block, snake_length, move_req, head_x, head_y,
    input  move_ack, body_count, snake_body_x, snake_body_y, scan_busy, scan_done, body_hit
  );

  modport slave (
    input  scan_start, x_block, y_block, snake_length, move_req, head_x, head_y,
    output move_ack, body_count, snake_body_x, snake_body_y, scan_busy, scan_done, body_hit
  );
endinterface

`default_nettype wire

// File: rtl/body_scan_scheduler.sv
//----------------------------------------------------------------------------
// body_scan_scheduler : snake segment store, per-block body scan, move arbiter
// Revision 1.0
//----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module body_scan_scheduler #(
  parameter int SNAKE_LENGTH_BIT = 6,
  parameter int MAX_SEGMENTS     = 16,
  parameter int COORD_BIT        = 7
) (
  input  logic                   clock_25,
  input  logic                   reset,
  body_scan_scheduler_if.slave   bus
);
  localparam int IDX_W = $clog2(MAX_SEGMENTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2,
    MOVE = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [COORD_BIT-1:0]        r_seg_x [MAX_SEGMENTS];
  logic [COORD_BIT-1:0]        r_seg_y [MAX_SEGMENTS];
  logic [COORD_BIT-1:0]        r_lat_x;
  logic [COORD_BIT-1:0]        r_lat_y;
  logic [IDX_W-1:0]            r_len;
  logic [SNAKE_LENGTH_BIT-1:0] r_body_count;
  logic                        r_acc;
  logic                        r_body_hit;
  logic [IDX_W-1:0]            w_idx;
  logic                        w_match;
  logic                        w_last;
  logic                        w_start;

  assign w_idx   = r_body_count[IDX_W-1:0];
  assign w_match = (r_seg_x[w_idx] == r_lat_x) && (r_seg_y[w_idx] == r_lat_y);
  // Only evaluated in SCAN, where the latched length is never zero.
  assign w_last  = (w_idx == (r_len - IDX_W'(1)));
  assign w_start = (r_state == IDLE) && bus.scan_start;

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.scan_start)
          w_next = (bus.snake_length == '0) ? DONE : SCAN;
        else if (bus.move_req)
          w_next = MOVE;
      end
      SCAN:    if (w_last) w_next = DONE;
      DONE:    w_next = bus.move_req ? MOVE : IDLE;
      MOVE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_lat_x      <= '0;
      r_lat_y      <= '0;
      r_len        <= '0;
      r_body_count <= '0;
      r_acc        <= 1'b0;
      r_body_hit   <= 1'b0;
    end else if (w_start) begin
      r_lat_x      <= bus.x_block;
      r_lat_y      <= bus.y_block;
      r_len        <= bus.snake_length;
      r_body_count <= '0;
      r_acc        <= 1'b0;
      // A zero-length scan still completes, and reports no hit.
      if (bus.snake_length == '0) r_body_hit <= 1'b0;
    end else if (r_state == SCAN) begin
      if (w_last) begin
        r_body_hit <= r_acc | w_match;
      end else begin
        r_body_count <= r_body_count + SNAKE_LENGTH_BIT'(1);
        r_acc        <= r_acc | w_match;
      end
    end
  end

  // Segment store: segment 0 is the newest; the oldest falls off the end.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_SEGMENTS; i++) begin
        r_seg_x[i] <= '0;
        r_seg_y[i] <= '0;
      end
    end else if (r_state == MOVE) begin
      for (int i = MAX_SEGMENTS - 1; i > 0; i--) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0] <= bus.head_x;
      r_seg_y[0] <= bus.head_y;
    end
  end

  assign bus.move_ack     = (r_state == MOVE);
  assign bus.scan_busy    = (r_state == SCAN);
  assign bus.scan_done    = (r_state == DONE);
  assign bus.body_hit     = r_body_hit;
  assign bus.body_count   = r_body_count;
  assign bus.snake_body_x = r_seg_x[w_idx];
  assign bus.snake_body_y = r_seg_y[w_idx];

endmodule

`default_nettype wire
